// File: rtl/afu_rd_arbiter.sv
// Round-robin arbiter sharing one CCI-P read-request path among NUM_REQ clients,
// with mdata tag allocation, response routing and drain sequencing. Optional stats: AFU_RD_ARB_STATS_EN.
module afu_rd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6,
    parameter int MAX_OUT = 48
) (
    input  logic                    clk,
    input  logic                    spl_reset,
    input  logic                    arb_en,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*42-1:0]   req_addr,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic                    tx_almost_full,
    output logic                    cor_tx_rd_valid,
    output logic [41:0]             cor_tx_rd_addr,
    output logic [15:0]             tx_rd_tag,
    input  logic                    io_rx_rd_valid,
    input  logic [15:0]             io_rx_tag,
    input  logic [511:0]            io_rx_data,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [511:0]            rsp_data,
    output logic [TAG_W-1:0]        rsp_tag,
    output logic [TAG_W:0]          outstanding,
    output logic                    drained,
    output logic                    err_spurious
`ifdef AFU_RD_ARB_STATS_EN
    ,
    output logic [31:0]             stat_issued,
    output logic [31:0]             stat_completed,
    output logic [15:0]             stat_max_lat
`endif
);

    localparam int NTAG  = 1 << TAG_W;
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int OUT_W = TAG_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NTAG-1:0]      tag_busy_q, tag_busy_d;
    logic [PTR_W-1:0]     tag_owner_q [NTAG];
    logic [PTR_W-1:0]     tag_owner_d [NTAG];
    logic [OUT_W-1:0]     outstanding_q, outstanding_d;
    logic                 tx_valid_q, tx_valid_d;
    logic [41:0]          tx_addr_q, tx_addr_d;
    logic [TAG_W-1:0]     tx_tag_q, tx_tag_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [511:0]         rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]     rsp_tag_q, rsp_tag_d;
    logic                 err_q, err_d;
    logic                 drained_q, drained_d;

    logic                 issue_ok_s;
    logic                 grant_found_s;
    logic [PTR_W-1:0]     grant_idx_s;
    logic [PTR_W-1:0]     cand_s;
    logic [41:0]          grant_addr_s;
    logic                 any_free_s;
    logic [TAG_W-1:0]     free_idx_s;
    logic                 accept_s;
    logic [TAG_W-1:0]     rx_idx_s;
    logic                 rx_hi_zero_s;
    logic                 rx_hit_s;

    // Rotating-priority grant search plus lowest-free-tag search.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        grant_addr_s  = '0;
        free_idx_s    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found_s && req_valid[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_addr_s = (grant_idx_s == PTR_W'(i)) ? req_addr[i*42 +: 42] : grant_addr_s;
        end
        for (int t = NTAG - 1; t >= 0; t--) begin
            free_idx_s = tag_busy_q[TAG_W'(t)] ? free_idx_s : TAG_W'(t);
        end
    end

    assign any_free_s   = ~(&tag_busy_q);
    assign issue_ok_s   = (state_q == ST_RUN) && !tx_almost_full && any_free_s
                          && (outstanding_q < OUT_W'(MAX_OUT));
    assign accept_s     = issue_ok_s && grant_found_s;
    assign req_ready    = accept_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_s) : '0;

    assign rx_idx_s     = io_rx_tag[TAG_W-1:0];
    assign rx_hi_zero_s = ((io_rx_tag >> TAG_W) == 16'd0);
    assign rx_hit_s     = io_rx_rd_valid && rx_hi_zero_s && tag_busy_q[rx_idx_s];

    // Next-state: FSM, tag table, issue and response registers.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        tag_busy_d    = tag_busy_q;
        tag_owner_d   = tag_owner_q;
        outstanding_d = outstanding_q;
        tx_valid_d    = accept_s;
        tx_addr_d     = tx_addr_q;
        tx_tag_d      = tx_tag_q;
        rsp_valid_d   = '0;
        rsp_data_d    = rsp_data_q;
        rsp_tag_d     = rsp_tag_q;
        err_d         = err_q;

        case (state_q)
            ST_IDLE:  state_d = arb_en ? ST_RUN : ST_IDLE;
            ST_RUN:   state_d = arb_en ? ST_RUN : ST_DRAIN;
            ST_DRAIN: begin
                if (arb_en) begin
                    state_d = ST_RUN;
                end else if (outstanding_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default:  state_d = ST_IDLE;
        endcase

        if (rx_hit_s) begin
            tag_busy_d[rx_idx_s] = 1'b0;
            rsp_valid_d          = {{(NUM_REQ-1){1'b0}}, 1'b1} << tag_owner_q[rx_idx_s];
            rsp_data_d           = io_rx_data;
            rsp_tag_d            = rx_idx_s;
        end else begin
            err_d = err_q | io_rx_rd_valid;
        end

        // The allocated tag was free last cycle, so it never collides with the freed one.
        if (accept_s) begin
            tag_busy_d[free_idx_s]  = 1'b1;
            tag_owner_d[free_idx_s] = grant_idx_s;
            rr_ptr_d  = (grant_idx_s == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + 1'b1;
            tx_addr_d = grant_addr_s;
            tx_tag_d  = free_idx_s;
        end else begin
            rr_ptr_d  = rr_ptr_q;
        end

        case ({accept_s, rx_hit_s})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1'b1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1'b1);
            default: outstanding_d = outstanding_q;
        endcase

        drained_d = (state_d == ST_IDLE) && (outstanding_d == '0);
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (spl_reset) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            tag_busy_q    <= '0;
            tag_owner_q   <= '{default: '0};
            outstanding_q <= '0;
            tx_valid_q    <= 1'b0;
            tx_addr_q     <= '0;
            tx_tag_q      <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            rsp_tag_q     <= '0;
            err_q         <= 1'b0;
            drained_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            tag_busy_q    <= tag_busy_d;
            tag_owner_q   <= tag_owner_d;
            outstanding_q <= outstanding_d;
            tx_valid_q    <= tx_valid_d;
            tx_addr_q     <= tx_addr_d;
            tx_tag_q      <= tx_tag_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_tag_q     <= rsp_tag_d;
            err_q         <= err_d;
            drained_q     <= drained_d;
        end
    end

    assign cor_tx_rd_valid = tx_valid_q;
    assign cor_tx_rd_addr  = tx_addr_q;
    assign tx_rd_tag       = {{(16-TAG_W){1'b0}}, tx_tag_q};
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign rsp_tag         = rsp_tag_q;
    assign outstanding     = outstanding_q;
    assign drained         = drained_q;
    assign err_spurious    = err_q;

`ifdef AFU_RD_ARB_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d;
    logic [31:0] stat_completed_q, stat_completed_d;
    logic [15:0] stat_max_lat_q, stat_max_lat_d;
    logic [15:0] cyc_q, cyc_d;
    logic [15:0] ts_q [NTAG];
    logic [15:0] ts_d [NTAG];
    logic [15:0] lat_s;

    // Timestamps record the issue cycle (accept + 1); latencies beyond 2^16 cycles alias.
    always_comb begin
        cyc_d            = cyc_q + 16'd1;
        ts_d             = ts_q;
        stat_issued_d    = stat_issued_q;
        stat_completed_d = stat_completed_q;
        stat_max_lat_d   = stat_max_lat_q;
        lat_s            = cyc_q - ts_q[rx_idx_s];
        if (accept_s) begin
            stat_issued_d    = stat_issued_q + 32'd1;
            ts_d[free_idx_s] = cyc_q + 16'd1;
        end else begin
            stat_issued_d    = stat_issued_q;
        end
        if (rx_hit_s) begin
            stat_completed_d = stat_completed_q + 32'd1;
            stat_max_lat_d   = (lat_s > stat_max_lat_q) ? lat_s : stat_max_lat_q;
        end else begin
            stat_completed_d = stat_completed_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (spl_reset) begin
            cyc_q            <= '0;
            ts_q             <= '{default: '0};
            stat_issued_q    <= '0;
            stat_completed_q <= '0;
            stat_max_lat_q   <= '0;
        end else begin
            cyc_q            <= cyc_d;
            ts_q             <= ts_d;
            stat_issued_q    <= stat_issued_d;
            stat_completed_q <= stat_completed_d;
            stat_max_lat_q   <= stat_max_lat_d;
        end
    end

    assign stat_issued    = stat_issued_q;
    assign stat_completed = stat_completed_q;
    assign stat_max_lat   = stat_max_lat_q;
`endif

endmodule

// File: tb/tb_afu_rd_arbiter.sv
// Self-checking bench for afu_rd_arbiter: directed table, multi-cycle scenarios and
// randomized traffic against a cycle-level reference model of the arbitration rules.
module tb_afu_rd_arbiter;
    localparam int NUM_REQ = 4;
    localparam int TAG_W   = 6;
    localparam int MAX_OUT = 48;
    localparam int NTAG    = 64;

    logic                  clk = 1'b0;
    logic                  spl_reset = 1'b1;
    logic                  arb_en = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ*42-1:0] req_addr = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  tx_almost_full = 1'b0;
    logic                  cor_tx_rd_valid;
    logic [41:0]           cor_tx_rd_addr;
    logic [15:0]           tx_rd_tag;
    logic                  io_rx_rd_valid = 1'b0;
    logic [15:0]           io_rx_tag = '0;
    logic [511:0]          io_rx_data = '0;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [511:0]          rsp_data;
    logic [TAG_W-1:0]      rsp_tag;
    logic [TAG_W:0]        outstanding;
    logic                  drained;
    logic                  err_spurious;

    afu_rd_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .spl_reset(spl_reset), .arb_en(arb_en),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .tx_almost_full(tx_almost_full), .cor_tx_rd_valid(cor_tx_rd_valid),
        .cor_tx_rd_addr(cor_tx_rd_addr), .tx_rd_tag(tx_rd_tag),
        .io_rx_rd_valid(io_rx_rd_valid), .io_rx_tag(io_rx_tag), .io_rx_data(io_rx_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .outstanding(outstanding), .drained(drained), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: 0 idle, 1 run, 2 drain
    int           m_state, m_rr, m_out;
    bit           m_busy [NTAG];
    int           m_owner [NTAG];
    bit           e_txv;
    logic [41:0]  e_txaddr;
    int           e_txtag;
    logic [3:0]   e_rspv;
    logic [511:0] e_rspdata;
    int           e_rsptag;
    bit           e_err, e_drained;

    logic [3:0]   s_ready;
    bit           s_acc;

    typedef struct {
        logic       en;
        logic [3:0] valid;
        logic [3:0] exp_ready;
        logic       exp_txv;
        logic [15:0] exp_tag;
        logic [41:0] exp_addr;
    } rr_vec_t;
    rr_vec_t rr_tab [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_data(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_rr = 0; m_out = 0;
        for (int t = 0; t < NTAG; t++) begin m_busy[t] = 1'b0; m_owner[t] = 0; end
        e_txv = 1'b0; e_txaddr = '0; e_txtag = 0; e_rspv = '0; e_rspdata = '0;
        e_rsptag = 0; e_err = 1'b0; e_drained = 1'b0;
    endtask

    // One clock: compare at negedge, advance model, return #1 after posedge.
    task automatic step();
        int g, ft, idx, nstate;
        bit issue_ok, hit;
        logic [3:0] exp_ready;
        @(negedge clk);
        chk("tx_valid", cor_tx_rd_valid, e_txv);
        if (e_txv) begin
            chk("tx_addr", cor_tx_rd_addr, e_txaddr);
            chk("tx_rd_tag", tx_rd_tag, e_txtag);
        end
        chk("rsp_valid", rsp_valid, e_rspv);
        if (e_rspv != 4'd0) begin
            chk_data("rsp_data", rsp_data, e_rspdata);
            chk("rsp_tag", rsp_tag, e_rsptag);
        end
        chk("outstanding", outstanding, m_out);
        chk("drained", drained, e_drained);
        chk("err_spurious", err_spurious, e_err);

        ft = -1;
        for (int t = 0; t < NTAG; t++) if (!m_busy[t] && ft < 0) ft = t;
        issue_ok = (m_state == 1) && !tx_almost_full && (ft >= 0) && (m_out < MAX_OUT);
        g = -1;
        if (issue_ok)
            for (int k = 0; k < NUM_REQ; k++)
                if (g < 0 && req_valid[(m_rr + k) % NUM_REQ]) g = (m_rr + k) % NUM_REQ;
        exp_ready = (g >= 0) ? 4'(1 << g) : 4'd0;
        chk("req_ready", req_ready, exp_ready);
        s_ready = req_ready;
        s_acc   = (req_ready & req_valid) != 4'd0;

        if (spl_reset) begin
            model_reset();
        end else begin
            idx = int'(io_rx_tag[5:0]);
            hit = io_rx_rd_valid && (io_rx_tag[15:6] == 10'd0) && m_busy[idx];
            e_rspv = 4'd0;
            if (hit) begin
                e_rspv = 4'(1 << m_owner[idx]);
                e_rspdata = io_rx_data;
                e_rsptag = idx;
                m_busy[idx] = 1'b0;
            end
            if (io_rx_rd_valid && !hit) e_err = 1'b1;
            e_txv = (g >= 0);
            if (g >= 0) begin
                m_busy[ft] = 1'b1; m_owner[ft] = g; m_rr = (g + 1) % NUM_REQ;
                e_txaddr = req_addr[42*g +: 42]; e_txtag = ft;
            end
            nstate = m_state;
            case (m_state)
                0: if (arb_en) nstate = 1;
                1: if (!arb_en) nstate = 2;
                default: if (arb_en) nstate = 1; else if (m_out == 0) nstate = 0;
            endcase
            m_out = m_out + ((g >= 0) ? 1 : 0) - (hit ? 1 : 0);
            m_state = nstate;
            e_drained = (m_state == 0) && (m_out == 0);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        spl_reset = 1'b1; step(); spl_reset = 1'b0;
    endtask

    task automatic issue_n(input int n);
        int got = 0;
        int cyc = 0;
        req_valid = 4'hF;
        while (got < n && cyc < 300) begin
            step();
            if (s_acc) got++;
            cyc++;
        end
        req_valid = 4'h0;
        chk("issue_count", got, n);
    endtask

    task automatic respond(input logic [15:0] tag, input logic [511:0] data);
        io_rx_rd_valid = 1'b1; io_rx_tag = tag; io_rx_data = data;
        step();
        io_rx_rd_valid = 1'b0; io_rx_tag = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int busyq[$];
        logic [15:0] rtag;
        logic [3:0] oo_exp [4];
        int oo_tag [4];

        rr_tab[0] = '{1'b1, 4'b1111, 4'b0000, 1'b0, 16'd0, 42'h000};
        rr_tab[1] = '{1'b1, 4'b1111, 4'b0001, 1'b1, 16'd0, 42'h100};
        rr_tab[2] = '{1'b1, 4'b1111, 4'b0010, 1'b1, 16'd1, 42'h101};
        rr_tab[3] = '{1'b1, 4'b1111, 4'b0100, 1'b1, 16'd2, 42'h102};
        rr_tab[4] = '{1'b1, 4'b1111, 4'b1000, 1'b1, 16'd3, 42'h103};
        rr_tab[5] = '{1'b1, 4'b1111, 4'b0001, 1'b1, 16'd4, 42'h100};
        rr_tab[6] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 16'd0, 42'h000};
        rr_tab[7] = '{1'b1, 4'b1010, 4'b0010, 1'b1, 16'd5, 42'h101};
        rr_tab[8] = '{1'b1, 4'b1001, 4'b1000, 1'b1, 16'd6, 42'h103};
        rr_tab[9] = '{1'b1, 4'b0001, 4'b0001, 1'b1, 16'd7, 42'h100};
        oo_tag = '{2, 0, 3, 1};
        oo_exp = '{4'b0100, 4'b0001, 4'b1000, 4'b0010};

        for (int i = 0; i < NUM_REQ; i++) req_addr[42*i +: 42] = 42'h100 + 42'(i);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        spl_reset = 1'b0;
        chk("reset_outstanding", outstanding, 0);
        chk("reset_tx_valid", cor_tx_rd_valid, 0);
        chk("reset_err", err_spurious, 0);

        // Round-robin table
        do_reset();
        for (int r = 0; r < 10; r++) begin
            arb_en = rr_tab[r].en; req_valid = rr_tab[r].valid;
            step();
            chk("rr_ready", s_ready, rr_tab[r].exp_ready);
            chk("rr_txv", cor_tx_rd_valid, rr_tab[r].exp_txv);
            if (rr_tab[r].exp_txv) begin
                chk("rr_tag", tx_rd_tag, rr_tab[r].exp_tag);
                chk("rr_addr", cor_tx_rd_addr, rr_tab[r].exp_addr);
            end
        end
        req_valid = '0;

        // Out-of-order return
        do_reset();
        arb_en = 1'b1;
        issue_n(4);
        chk("ooo_out4", outstanding, 4);
        for (int i = 0; i < 4; i++) begin
            respond(16'(oo_tag[i]), 512'(10 + i));
            chk("ooo_rsp_valid", rsp_valid, oo_exp[i]);
            chk("ooo_rsp_data", rsp_data[63:0], 64'(10 + i));
        end
        chk("ooo_out0", outstanding, 0);

        // Full
        do_reset();
        arb_en = 1'b1;
        issue_n(MAX_OUT);
        req_valid = 4'hF;
        cnt = 0;
        repeat (5) begin step(); if (s_ready != 4'd0) cnt++; end
        chk("full_no_ready", cnt, 0);
        chk("full_out", outstanding, MAX_OUT);
        respond(16'd5, rnd512());
        issue_n(1);
        chk("full_reuse_tag", tx_rd_tag, 5);
        chk("full_reuse_valid", cor_tx_rd_valid, 1);

        // Back-pressure
        do_reset();
        arb_en = 1'b1; req_valid = 4'hF;
        step(); step();
        tx_almost_full = 1'b1;
        cnt = 0;
        repeat (10) begin step(); if (s_ready != 4'd0) cnt++; end
        chk("bp_blocked", cnt, 0);
        tx_almost_full = 1'b0;
        step();
        chk("bp_resume", s_ready != 4'd0, 1);
        req_valid = '0;

        // Drain
        do_reset();
        arb_en = 1'b1;
        issue_n(3);
        arb_en = 1'b0;
        step();
        req_valid = 4'hF;
        cnt = 0;
        repeat (3) begin step(); if (s_ready != 4'd0) cnt++; end
        respond(16'd0, rnd512());
        respond(16'd1, rnd512());
        chk("drain_not_done", drained, 0);
        respond(16'd2, rnd512());
        chk("drain_lag", drained, 0);
        cnt = cnt + ((s_ready != 4'd0) ? 1 : 0);
        chk("drain_no_grant", cnt, 0);
        cnt = 0;
        repeat (4) begin if (drained !== 1'b1) begin step(); cnt++; end end
        chk("drain_done", drained, 1);
        req_valid = '0;

        // Spurious and reset
        do_reset();
        arb_en = 1'b1;
        step();
        respond(16'd9, rnd512());
        chk("spur_err", err_spurious, 1);
        chk("spur_no_rsp", rsp_valid, 0);
        do_reset();
        chk("rst_err", err_spurious, 0);
        chk("rst_out", outstanding, 0);
        issue_n(1);
        chk("rst_tag0", tx_rd_tag, 0);
        respond(16'h0040, rnd512());
        chk("hi_bits_err", err_spurious, 1);
        chk("hi_bits_no_rsp", rsp_valid, 0);
        chk("hi_bits_out", outstanding, 1);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            arb_en = ($urandom_range(0, 9) != 0);
            req_valid = 4'($urandom);
            for (int i = 0; i < NUM_REQ; i++) req_addr[42*i +: 42] = {10'($urandom), 32'($urandom)};
            tx_almost_full = ($urandom_range(0, 4) == 0);
            spl_reset = ($urandom_range(0, 499) == 0);
            busyq.delete();
            for (int t = 0; t < NTAG; t++) if (m_busy[t]) busyq.push_back(t);
            io_rx_rd_valid = 1'b0;
            rtag = '0;
            cnt = $urandom_range(0, 99);
            if (cnt < 45 && busyq.size() > 0) begin
                io_rx_rd_valid = 1'b1;
                rtag = 16'(busyq[$urandom_range(0, busyq.size() - 1)]);
            end else if (cnt < 47) begin
                io_rx_rd_valid = 1'b1;
                rtag = 16'($urandom);
            end
            io_rx_tag = rtag;
            io_rx_data = rnd512();
            step();
        end
        spl_reset = 1'b0; io_rx_rd_valid = 1'b0; tx_almost_full = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
